// File: rtl/datapath_seq.sv
// Sequenced register-file datapath: start runs LDA -> LDB -> EXEC -> WB with {N,V,Z} status.
// Optional macro DATAPATH_SAT_EN clamps add/sub results on signed overflow.
module datapath_seq #(
  parameter int W  = 16,
  parameter int RA = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [RA-1:0] rn,
  input  logic [RA-1:0] rm,
  input  logic [RA-1:0] rd,
  input  logic [1:0]    shift,
  input  logic [1:0]    aluop,
  input  logic          asel,
  input  logic          bsel,
  input  logic [W-1:0]  imm,
  input  logic          wb_en,
  input  logic          ext_we,
  input  logic [RA-1:0] ext_addr,
  input  logic [W-1:0]  ext_data,
  output logic [W-1:0]  datapath_out,
  output logic [2:0]    status,
  output logic          busy,
  output logic          done
);

  localparam int NREG = 2**RA;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDA  = 3'd1,
    S_LDB  = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_t;

  state_t          state_r;
  logic [W-1:0]    regs_r [NREG];
  logic [RA-1:0]   rn_r, rm_r, rd_r;
  logic [1:0]      shift_r, aluop_r;
  logic            asel_r, bsel_r, wb_en_r;
  logic [W-1:0]    imm_r;
  logic [W-1:0]    a_r, b_r, c_r;
  logic [2:0]      status_r;
  logic            busy_r, done_r;

  logic [W-1:0]    ain_s, bin_s, sum_s, diff_s, result_s, c_next_s;
  logic            v_s;
  logic [2:0]      flags_s;

  function automatic logic [W-1:0] shift1(input logic [W-1:0] val, input logic [1:0] mode);
    logic [W-1:0] res;
    case (mode)
      2'b00:   res = val;
      2'b01:   res = {val[W-2:0], 1'b0};
      2'b10:   res = {1'b0, val[W-1:1]};
      2'b11:   res = {val[W-1], val[W-1:1]};
      default: res = val;
    endcase
    return res;
  endfunction

  // Operand selection, ALU and flag generation for the EXEC state
  always_comb begin
    ain_s  = asel_r ? {W{1'b0}} : a_r;
    bin_s  = bsel_r ? imm_r : shift1(b_r, shift_r);
    sum_s  = ain_s + bin_s;
    diff_s = ain_s - bin_s;
    result_s = sum_s;
    v_s      = 1'b0;
    case (aluop_r)
      2'b00: begin
        result_s = sum_s;
        v_s      = (ain_s[W-1] == bin_s[W-1]) && (sum_s[W-1] != ain_s[W-1]);
      end
      2'b01: begin
        result_s = diff_s;
        v_s      = (ain_s[W-1] != bin_s[W-1]) && (diff_s[W-1] != ain_s[W-1]);
      end
      2'b10:   result_s = ain_s & bin_s;
      2'b11:   result_s = ~bin_s;
      default: result_s = {W{1'b0}};
    endcase
`ifdef DATAPATH_SAT_EN
    // Overflow direction always follows Ain's sign for both add and sub
    c_next_s = v_s ? (ain_s[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : result_s;
`else
    c_next_s = result_s;
`endif
    flags_s = {c_next_s[W-1], v_s, (c_next_s == {W{1'b0}})};
  end

  // Sequencer, operand/result registers and register file
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= S_IDLE;
      for (int i = 0; i < NREG; i++) regs_r[i] <= {W{1'b0}};
      rn_r     <= {RA{1'b0}};
      rm_r     <= {RA{1'b0}};
      rd_r     <= {RA{1'b0}};
      shift_r  <= 2'b00;
      aluop_r  <= 2'b00;
      asel_r   <= 1'b0;
      bsel_r   <= 1'b0;
      wb_en_r  <= 1'b0;
      imm_r    <= {W{1'b0}};
      a_r      <= {W{1'b0}};
      b_r      <= {W{1'b0}};
      c_r      <= {W{1'b0}};
      status_r <= 3'b000;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (ext_we) regs_r[ext_addr] <= ext_data;
          if (start) begin
            rn_r    <= rn;
            rm_r    <= rm;
            rd_r    <= rd;
            shift_r <= shift;
            aluop_r <= aluop;
            asel_r  <= asel;
            bsel_r  <= bsel;
            imm_r   <= imm;
            wb_en_r <= wb_en;
            busy_r  <= 1'b1;
            state_r <= S_LDA;
          end
        end
        S_LDA: begin
          a_r     <= regs_r[rn_r];
          state_r <= S_LDB;
        end
        S_LDB: begin
          b_r     <= regs_r[rm_r];
          state_r <= S_EXEC;
        end
        S_EXEC: begin
          c_r      <= c_next_s;
          status_r <= flags_s;
          done_r   <= 1'b1;
          state_r  <= S_WB;
        end
        S_WB: begin
          if (wb_en_r) regs_r[rd_r] <= c_r;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign datapath_out = c_r;
  assign status       = status_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule

// File: tb/tb_datapath_seq.sv
// Scoreboard bench for datapath_seq: a W=16/RA=3 instance plus a W=8/RA=2 instance on shared stimulus.
module tb_datapath_seq;

  logic        clk = 1'b0;
  logic        reset, start, asel, bsel, wb_en, ext_we;
  logic [2:0]  rn, rm, rd, ext_addr;
  logic [1:0]  shift, aluop;
  logic [15:0] imm, ext_data;
  logic [15:0] out16;
  logic [2:0]  st16;
  logic        busy16, done16;
  logic [7:0]  out8;
  logic [2:0]  st8;
  logic        busy8, done8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] c;
    logic [2:0]  st;
    string       tag;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];

`ifdef DATAPATH_SAT_EN
  localparam logic [15:0] OVF16_C = 16'h7FFF;
  localparam logic [2:0]  OVF16_S = 3'b010;
  localparam logic [15:0] OVF8_C  = 16'h007F;
  localparam logic [2:0]  OVF8_S  = 3'b010;
  localparam logic [2:0]  RD8_S   = 3'b000;
`else
  localparam logic [15:0] OVF16_C = 16'h8000;
  localparam logic [2:0]  OVF16_S = 3'b110;
  localparam logic [15:0] OVF8_C  = 16'h0080;
  localparam logic [2:0]  OVF8_S  = 3'b110;
  localparam logic [2:0]  RD8_S   = 3'b100;
`endif

  always #5 clk = ~clk;

  datapath_seq #(.W(16), .RA(3)) dut16 (
    .clk(clk), .reset(reset), .start(start), .rn(rn), .rm(rm), .rd(rd),
    .shift(shift), .aluop(aluop), .asel(asel), .bsel(bsel), .imm(imm), .wb_en(wb_en),
    .ext_we(ext_we), .ext_addr(ext_addr), .ext_data(ext_data),
    .datapath_out(out16), .status(st16), .busy(busy16), .done(done16)
  );

  datapath_seq #(.W(8), .RA(2)) dut8 (
    .clk(clk), .reset(reset), .start(start), .rn(rn[1:0]), .rm(rm[1:0]), .rd(rd[1:0]),
    .shift(shift), .aluop(aluop), .asel(asel), .bsel(bsel), .imm(imm[7:0]), .wb_en(wb_en),
    .ext_we(ext_we), .ext_addr(ext_addr[1:0]), .ext_data(ext_data[7:0]),
    .datapath_out(out8), .status(st8), .busy(busy8), .done(done8)
  );

  task automatic check(input logic [15:0] obs, input logic [15:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic ext_write(input logic [2:0] a, input logic [15:0] d);
    ext_we   = 1'b1;
    ext_addr = a;
    ext_data = d;
    @(negedge clk);
    ext_we   = 1'b0;
  endtask

  // Drives one start pulse from IDLE and records the expected result; returns in LDA.
  task automatic launch(input logic [2:0] a_rn, input logic [2:0] a_rm, input logic [2:0] a_rd,
                        input logic [1:0] a_sh, input logic [1:0] a_op, input logic a_as,
                        input logic a_bs, input logic [15:0] a_imm, input logic a_we,
                        input logic [15:0] ec, input logic [2:0] es, input string tag);
    rn = a_rn; rm = a_rm; rd = a_rd; shift = a_sh; aluop = a_op;
    asel = a_as; bsel = a_bs; imm = a_imm; wb_en = a_we;
    start = 1'b1;
    q16.push_back('{ec, es, tag});
    @(negedge clk);
    start = 1'b0;
    check({15'h0, busy16}, 16'h0001, {tag, "/busy"});
  endtask

  // Waits (bounded) for done, then pops and compares both scoreboards; returns in IDLE.
  task automatic wait_done(input int lat0, input string tag);
    int   lat;
    logic seen;
    exp_t e;
    lat  = lat0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done16) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    check({15'h0, seen}, 16'h0001, {tag, "/done_seen"});
    if (seen) begin
      check(16'(lat), 16'd4, {tag, "/latency"});
      if (q16.size() > 0) begin
        e = q16.pop_front();
        check(out16, e.c, {e.tag, "/c16"});
        check({13'h0, st16}, {13'h0, e.st}, {e.tag, "/st16"});
      end
      if (q8.size() > 0) begin
        e = q8.pop_front();
        check({15'h0, done8}, 16'h0001, {e.tag, "/done8"});
        check({8'h0, out8}, e.c, {e.tag, "/c8"});
        check({13'h0, st8}, {13'h0, e.st}, {e.tag, "/st8"});
      end
    end else begin
      q16.delete();
      q8.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [2:0] a_rn, input logic [2:0] a_rm, input logic [2:0] a_rd,
                     input logic [1:0] a_sh, input logic [1:0] a_op, input logic a_as,
                     input logic a_bs, input logic [15:0] a_imm, input logic a_we,
                     input logic [15:0] ec, input logic [2:0] es, input string tag);
    launch(a_rn, a_rm, a_rd, a_sh, a_op, a_as, a_bs, a_imm, a_we, ec, es, tag);
    wait_done(1, tag);
  endtask

  // Reads a register as C = R[r] + 0 without writeback.
  task automatic read_reg(input logic [2:0] r, input logic [15:0] ec, input logic [2:0] es,
                          input string tag);
    run(r, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b1, 16'h0000, 1'b0, ec, es, tag);
  endtask

  task automatic count_done(input int n, input string tag);
    int nd;
    nd = 0;
    for (int i = 0; i < n; i++) begin
      if (done16) nd++;
      @(negedge clk);
    end
    check(16'(nd), 16'd0, tag);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rn = 3'd0; rm = 3'd0; rd = 3'd0; shift = 2'b00;
    aluop = 2'b00; asel = 1'b0; bsel = 1'b0; imm = 16'h0; wb_en = 1'b0;
    ext_we = 1'b0; ext_addr = 3'd0; ext_data = 16'h0;
    @(negedge clk);
    do_reset();
    check(out16, 16'h0000, "rst/c16");
    check({13'h0, st16}, 16'h0000, "rst/st16");
    check({15'h0, busy16}, 16'h0000, "rst/busy16");
    check({15'h0, done16}, 16'h0000, "rst/done16");
    check({8'h0, out8}, 16'h0000, "rst/c8");
    check({15'h0, busy8}, 16'h0000, "rst/busy8");

    // Basic add with LSL1 on B and writeback
    ext_write(3'd0, 16'd7);
    ext_write(3'd1, 16'd2);
    run(3'd1, 3'd0, 3'd2, 2'b01, 2'b00, 1'b0, 1'b0, 16'h0, 1'b1, 16'd16, 3'b000, "add_lsl");
    read_reg(3'd2, 16'd16, 3'b000, "rd_r2");

    // Add, then compare-style sub without writeback
    ext_write(3'd3, 16'd41);
    ext_write(3'd4, 16'd10);
    run(3'd3, 3'd4, 3'd5, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0, 1'b1, 16'd51, 3'b000, "add_51");
    run(3'd5, 3'd5, 3'd0, 2'b00, 2'b01, 1'b0, 1'b0, 16'h0, 1'b0, 16'd0, 3'b001, "sub_cmp");
    read_reg(3'd5, 16'd51, 3'b000, "rd_r5");

    // Signed overflow on add with immediate
    ext_write(3'd0, 16'h7FFF);
    run(3'd0, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b1, 16'h0001, 1'b0, OVF16_C, OVF16_S, "ovf16");

    // Shifter modes and NOT B
    ext_write(3'd1, 16'h8002);
    run(3'd1, 3'd1, 3'd0, 2'b10, 2'b00, 1'b1, 1'b0, 16'h0, 1'b0, 16'h4001, 3'b000, "lsr1");
    run(3'd1, 3'd1, 3'd0, 2'b11, 2'b00, 1'b1, 1'b0, 16'h0, 1'b0, 16'hC001, 3'b100, "asr1");
    run(3'd1, 3'd1, 3'd0, 2'b01, 2'b00, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0004, 3'b000, "lsl1");
    run(3'd1, 3'd1, 3'd0, 2'b00, 2'b11, 1'b0, 1'b0, 16'h0, 1'b0, 16'h7FFD, 3'b000, "not_b");

    // Start and ext_we pulsed during LDB are ignored
    launch(3'd3, 3'd0, 3'd0, 2'b00, 2'b00, 1'b0, 1'b1, 16'h0, 1'b0, 16'd41, 3'b000, "stray");
    @(negedge clk);
    start = 1'b1; ext_we = 1'b1; ext_addr = 3'd3; ext_data = 16'h1234;
    @(negedge clk);
    start = 1'b0; ext_we = 1'b0;
    wait_done(3, "stray");
    count_done(8, "stray/extra_done");
    read_reg(3'd3, 16'd41, 3'b000, "stray/r3");

    // Reset during EXEC aborts the op targeting R2
    launch(3'd3, 3'd0, 3'd2, 2'b00, 2'b00, 1'b0, 1'b1, 16'h0, 1'b1, 16'd41, 3'b000, "abort");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q16.delete();
    check({15'h0, busy16}, 16'h0000, "abort/busy");
    check({15'h0, done16}, 16'h0000, "abort/done");
    check(out16, 16'h0000, "abort/c");
    count_done(8, "abort/no_done");
    read_reg(3'd2, 16'h0000, 3'b001, "abort/r2");
    read_reg(3'd3, 16'h0000, 3'b001, "abort/r3");
    ext_write(3'd1, 16'd5);
    run(3'd1, 3'd0, 3'd7, 2'b00, 2'b00, 1'b0, 1'b1, 16'd3, 1'b1, 16'd8, 3'b000, "post_abort");
    read_reg(3'd7, 16'd8, 3'b000, "rd_r7");

    // W=8, RA=2 instance: 0x7F + 0x01 into R3
    do_reset();
    ext_write(3'd0, 16'h007F);
    ext_write(3'd1, 16'h0001);
    q8.push_back('{OVF8_C, OVF8_S, "w8_add"});
    run(3'd0, 3'd1, 3'd3, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0080, 3'b000, "w8_add");
    q8.push_back('{OVF8_C, RD8_S, "w8_r3"});
    read_reg(3'd3, 16'h0080, 3'b000, "w8_r3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
